// File: rtl/onehot_span_decoder_pkg.sv
// Shared types for the priority-encoder back end: index width helper and the
// result word carried through the span decoder's FIFO.
package priority_pkg;
  // Struct fields are sized for the widest supported vector (WIDTH <= 256);
  // narrower instances use the low bits and leave the rest zero.
  localparam int IDX_W_MAX = 8;

  function automatic int idx_w(input int width);
    return $clog2(width);
  endfunction

  typedef struct packed {
    logic [IDX_W_MAX-1:0] left_idx;
    logic [IDX_W_MAX-1:0] right_idx;
    logic [IDX_W_MAX:0]   span;
    logic                 empty;
    logic                 onehot_err;
  } span_result_t;
endpackage

// File: rtl/onehot_span_decoder_if.sv
// Input vectors from the encoder plus the ready/valid result bus.
interface onehot_span_decoder_if #(
  parameter int WIDTH      = 32,
  parameter int DROP_CNT_W = 8
);
  import priority_pkg::*;
  localparam int IDX_W = idx_w(WIDTH);

  logic                  data_val_i;
  logic [WIDTH-1:0]      data_left_i;
  logic [WIDTH-1:0]      data_right_i;
  logic                  data_ready_i;
  logic                  data_val_o;
  logic [IDX_W-1:0]      left_idx_o;
  logic [IDX_W-1:0]      right_idx_o;
  logic [IDX_W:0]        span_o;
  logic                  empty_o;
  logic                  onehot_err_o;
  logic                  overflow_o;
  logic [DROP_CNT_W-1:0] drop_cnt_o;

  modport slave (
    input  data_val_i, data_left_i, data_right_i, data_ready_i,
    output data_val_o, left_idx_o, right_idx_o, span_o, empty_o,
           onehot_err_o, overflow_o, drop_cnt_o
  );

  modport master (
    output data_val_i, data_left_i, data_right_i, data_ready_i,
    input  data_val_o, left_idx_o, right_idx_o, span_o, empty_o,
           onehot_err_o, overflow_o, drop_cnt_o
  );
endinterface

// File: rtl/onehot_span_decoder_onehot_to_bin.sv
// One-hot to binary: index is the OR of set-bit positions; multi flags >1 bit set.
module onehot_to_bin
  import priority_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]        vec,
  output logic [idx_w(WIDTH)-1:0] idx,
  output logic                    zero,
  output logic                    multi
);
  localparam int IDX_W = idx_w(WIDTH);

  logic seen;

  always_comb begin
    idx   = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
        idx   = idx | IDX_W'(i);
      end
    end
  end

  assign zero = ~|vec;
endmodule

// File: rtl/onehot_span_decoder.sv
// Registered one-hot decode and span calculation feeding a show-ahead result
// FIFO; results arriving at a full FIFO with no pop are dropped and counted.
module onehot_span_decoder
  import priority_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 8
) (
  input logic                  clk_i,
  input logic                  srst_i,
  onehot_span_decoder_if.slave bus
);
  localparam int IDX_W = idx_w(WIDTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] l_idx, r_idx;
  logic             l_zero, r_zero, l_multi, r_multi;

  onehot_to_bin #(.WIDTH(WIDTH)) u_left (
    .vec(bus.data_left_i), .idx(l_idx), .zero(l_zero), .multi(l_multi)
  );
  onehot_to_bin #(.WIDTH(WIDTH)) u_right (
    .vec(bus.data_right_i), .idx(r_idx), .zero(r_zero), .multi(r_multi)
  );

  span_result_t res;
  logic         inverted;

  always_comb begin
    res                      = '0;
    inverted                 = l_idx < r_idx;
    res.left_idx[IDX_W-1:0]  = l_idx;
    res.right_idx[IDX_W-1:0] = r_idx;
    res.empty                = l_zero & r_zero;
    res.onehot_err           = l_multi | r_multi | (l_zero ^ r_zero) | inverted;
    if (!res.empty && !inverted)
      res.span[IDX_W:0] = ({1'b0, l_idx} - {1'b0, r_idx}) + (IDX_W+1)'(1);
  end

  logic         s1_vld;
  span_result_t s1_res;

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      s1_vld <= 1'b0;
      s1_res <= '0;
    end else begin
      s1_vld <= bus.data_val_i;
      if (bus.data_val_i) s1_res <= res;
    end
  end

  span_result_t          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, rd_next;
  logic [CNT_W-1:0]      count, cnt_next;
  span_result_t          head_q, head_next;
  logic                  val_q, ovf_q;
  logic [DROP_CNT_W-1:0] drop_q;
  logic                  full, pop, push, drop;

  always_comb begin
    full     = count == CNT_W'(FIFO_DEPTH);
    pop      = val_q & bus.data_ready_i;
    push     = s1_vld & (~full | pop);
    drop     = s1_vld & full & ~pop;
    rd_next  = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    cnt_next = count;
    if (push && !pop)      cnt_next = count + CNT_W'(1);
    else if (!push && pop) cnt_next = count - CNT_W'(1);
    // Head register mirrors mem[rd_ptr]; bypass the write when the new head
    // is the word being pushed this cycle, otherwise hold the last value.
    head_next = head_q;
    if (cnt_next != '0)
      head_next = (push && wr_ptr == rd_next) ? s1_res : mem[rd_next];
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= s1_res;
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
      val_q  <= 1'b0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_next;
      count  <= cnt_next;
      head_q <= head_next;
      val_q  <= cnt_next != '0;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + DROP_CNT_W'(1);
      end
    end
  end

  assign bus.data_val_o   = val_q;
  assign bus.left_idx_o   = head_q.left_idx[IDX_W-1:0];
  assign bus.right_idx_o  = head_q.right_idx[IDX_W-1:0];
  assign bus.span_o       = head_q.span[IDX_W:0];
  assign bus.empty_o      = head_q.empty;
  assign bus.onehot_err_o = head_q.onehot_err;
  assign bus.overflow_o   = ovf_q;
  assign bus.drop_cnt_o   = drop_q;

  generate
    if (IDX_W < IDX_W_MAX) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^{head_q.left_idx[IDX_W_MAX-1:IDX_W],
                           head_q.right_idx[IDX_W_MAX-1:IDX_W],
                           head_q.span[IDX_W_MAX:IDX_W+1]};
    end
  endgenerate
endmodule

// File: tb/tb_onehot_span_decoder.sv
// Scoreboarded bench: driver queues hand-computed results, monitor checks pops.
module tb_onehot_span_decoder;
  localparam int W = 32, D = 4, DW = 8;

  typedef struct {
    int l, r, s;
    bit e, err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  onehot_span_decoder_if #(.WIDTH(W), .DROP_CNT_W(DW)) bus ();

  onehot_span_decoder #(.WIDTH(W), .FIFO_DEPTH(D), .DROP_CNT_W(DW)) dut (
    .clk_i(clk), .srst_i(rst), .bus(bus)
  );

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_val"}, 32'(bus.data_val_o), 0);
    chk({tag, "_lidx"}, 32'(bus.left_idx_o), 0);
    chk({tag, "_ridx"}, 32'(bus.right_idx_o), 0);
    chk({tag, "_span"}, 32'(bus.span_o), 0);
    chk({tag, "_empty"}, 32'(bus.empty_o), 0);
    chk({tag, "_err"}, 32'(bus.onehot_err_o), 0);
    chk({tag, "_ovf"}, 32'(bus.overflow_o), 0);
    chk({tag, "_drop"}, 32'(bus.drop_cnt_o), 0);
  endtask

  // Monitor: every accepted head is compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.data_val_o && bus.data_ready_i) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got l=%0d r=%0d want none", bus.left_idx_o, bus.right_idx_o);
        end else begin
          e = q.pop_front();
          chk("pop_lidx", 32'(bus.left_idx_o), e.l);
          chk("pop_ridx", 32'(bus.right_idx_o), e.r);
          chk("pop_span", 32'(bus.span_o), e.s);
          chk("pop_empty", 32'(bus.empty_o), 32'(e.e));
          chk("pop_err", 32'(bus.onehot_err_o), 32'(e.err));
        end
      end
    end
  end

  task automatic send_raw(input logic [31:0] l, input logic [31:0] r, input bit keep,
                          input int el, input int er, input int es, input bit ee, input bit eerr);
    exp_t x;
    @(posedge clk); #1;
    bus.data_val_i   = 1'b1;
    bus.data_left_i  = l;
    bus.data_right_i = r;
    x.l = el; x.r = er; x.s = es; x.e = ee; x.err = eerr;
    if (keep) q.push_back(x);
  endtask

  task automatic send_bits(input int lb, input int rb, input bit keep);
    send_raw(32'd1 << lb, 32'd1 << rb, keep, lb, rb, lb - rb + 1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.data_val_i = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1;
    bus.data_ready_i = v;
  endtask

  initial begin
    rst = 1'b1;
    bus.data_val_i   = 1'b0;
    bus.data_left_i  = '0;
    bus.data_right_i = '0;
    bus.data_ready_i = 1'b0;
    #12;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    set_ready(1'b1);

    // Basic decode and 2-cycle latency.
    send_raw(32'h0000_0100, 32'h0000_0004, 1'b1, 8, 2, 7, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("lat_cycle1_val", 32'(bus.data_val_o), 0);
    @(negedge clk);
    chk("lat_cycle2_val", 32'(bus.data_val_o), 1);

    // Single bit, empty, malformed, inverted, one vector zero.
    send_raw(32'h8000_0000, 32'h8000_0000, 1'b1, 31, 31, 1, 1'b0, 1'b0);
    send_raw(32'h0000_0000, 32'h0000_0000, 1'b1, 0, 0, 0, 1'b1, 1'b0);
    send_raw(32'h0000_0003, 32'h0000_0001, 1'b1, 1, 0, 2, 1'b0, 1'b1);
    send_raw(32'h0000_0001, 32'h8000_0000, 1'b1, 0, 31, 0, 1'b0, 1'b1);
    send_raw(32'h8000_0000, 32'h0000_0000, 1'b1, 31, 0, 32, 1'b0, 1'b1);
    idle();
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("no_drop_drop", 32'(bus.drop_cnt_o), 0);
    chk("no_drop_ovf", 32'(bus.overflow_o), 0);

    // Stalled burst of 6 into a 4-deep FIFO: last two dropped.
    set_ready(1'b0);
    for (int k = 0; k < 6; k++) send_bits(k + 1, 0, k < 4);
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stall_val", 32'(bus.data_val_o), 1);
    chk("stall_head_lidx", 32'(bus.left_idx_o), 1);
    chk("stall_head_span", 32'(bus.span_o), 2);
    chk("stall_drop", 32'(bus.drop_cnt_o), 2);
    chk("stall_ovf", 32'(bus.overflow_o), 1);
    set_ready(1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_val", 32'(bus.data_val_o), 1);
    end
    @(negedge clk);
    chk("drain_done_val", 32'(bus.data_val_o), 0);

    // Full FIFO: push arrives in the same cycle as a pop, so nothing is dropped.
    set_ready(1'b0);
    for (int k = 0; k < 4; k++) send_bits(10 + k, k, 1'b1);
    idle();
    repeat (3) @(posedge clk);
    send_bits(20, 19, 1'b1);
    @(posedge clk); #1;
    bus.data_val_i   = 1'b0;
    bus.data_ready_i = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("pushpop_drop", 32'(bus.drop_cnt_o), 2);
    chk("pushpop_val", 32'(bus.data_val_o), 0);
    chk("pushpop_queue", 32'(q.size()), 0);

    // Reset mid-burst discards everything.
    set_ready(1'b0);
    for (int k = 0; k < 3; k++) send_bits(30 - k, 0, 1'b1);
    idle();
    repeat (2) @(posedge clk);
    set_ready(1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_zero_outputs("midrst");
    q.delete();
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_val", 32'(bus.data_val_o), 0);

    send_bits(5, 5, 1'b1);
    idle();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("final_queue", 32'(q.size()), 0);
    chk("final_drop", 32'(bus.drop_cnt_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/onehot_span_decoder.md
Name: onehot_span_decoder

Overview:
- Downstream stage of the priority encoder: consumes its registered leftmost/rightmost one-hot vectors and valid.
- Converts both vectors to binary bit indices and computes the occupied span (left_idx - right_idx + 1).
- Flags empty and malformed (non-one-hot) inputs.
- Buffers results in a small FIFO with a ready/valid output, because the encoder has no backpressure.

Parameters:
- WIDTH, 32, width of the one-hot input vectors; must be >= 2.
- FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2.
- DROP_CNT_W, 8, width of the saturating drop counter.

Ports:
- clk_i  input  1  clock.
- srst_i  input  1  reset; asynchronous, active-high.
- data_val_i  input  1  input vectors valid; single-cycle qualifier, no handshake.
- data_left_i  input  WIDTH  one-hot of the most significant set bit.
- data_right_i  input  WIDTH  one-hot of the least significant set bit.
- data_ready_i  input  1  downstream can accept the head result.
- data_val_o  output  1  head result valid.
- left_idx_o  output  IDX_W  binary index of the left bit; IDX_W = $clog2(WIDTH).
- right_idx_o  output  IDX_W  binary index of the right bit.
- span_o  output  IDX_W+1  left_idx - right_idx + 1; 0 when empty.
- empty_o  output  1  both inputs all-zero.
- onehot_err_o  output  1  either input has more than one bit set.
- overflow_o  output  1  sticky; set when a result was dropped.
- drop_cnt_o  output  DROP_CNT_W  saturating count of dropped results.

Behaviour:
- Reset (async, srst_i high): all outputs 0; FIFO empty (pointers 0, count 0); stage-1 valid 0.
- Stage 1, decode (registered):
  - Captured on every cycle with data_val_i = 1. No input stall exists.
  - Index = OR of bit positions whose bit is set.
  - onehot_err = popcount(left) > 1 OR popcount(right) > 1. Indices are then the OR result (don't-care, but deterministic).
  - empty = (left == 0) AND (right == 0). Then idx = 0 and span = 0.
  - If exactly one vector is zero: onehot_err = 1, empty = 0.
  - Span is computed in IDX_W+1 bits. If left_idx < right_idx (malformed input), span = 0 and onehot_err = 1.
- Stage 2, FIFO:
  - Stage-1 valid result is pushed the cycle after capture.
  - Show-ahead: the head appears on the outputs the cycle after the push into an empty FIFO.
  - Latency from data_val_i to data_val_o is 2 cycles with an empty FIFO.
- Output handshake:
  - Pop when data_val_o && data_ready_i.
  - Outputs hold stable while data_val_o = 1 and data_ready_i = 0.
- Full FIFO with a pending push:
  - If a pop occurs in the same cycle, the push succeeds and count is unchanged.
  - Otherwise the result is dropped: overflow_o is set (sticky until reset) and drop_cnt_o increments, saturating at all-ones.
- Empty FIFO: data_val_o = 0 and output fields hold their last values. data_ready_i is ignored.
- Pointers wrap modulo FIFO_DEPTH. Count uses $clog2(FIFO_DEPTH)+1 bits.
- Reset asserted mid-stream: all in-flight and buffered results are discarded immediately.
- No combinational path from any input to any output.

Decomposition:
- Shared package priority_pkg:
  - IDX_W function (clog2 wrapper).
  - Typedef span_result_t, a packed struct {left_idx, right_idx, span, empty, onehot_err}, used as the FIFO word.
- One sub-module, onehot_to_bin: combinational one-hot to binary plus a multi-hot flag, instantiated twice.
- FIFO is inline, a register array.

Test Plan:
- Encoder output left=32'h0000_0100, right=32'h0000_0004, ready=1 -> 2 cycles later: left_idx=8, right_idx=2, span=7, empty=0, err=0.
- Single set bit: left=right=32'h8000_0000 -> left_idx=31, right_idx=31, span=1. Then both 0 -> empty=1, idx=0, span=0.
- Malformed left=32'h0000_0003 -> onehot_err_o=1. Also left=32'h1, right=32'h8000_0000 -> span=0, err=1.
- ready=0 with 6 consecutive valid inputs, FIFO_DEPTH=4 -> 4 results buffered, drop_cnt_o=2, overflow_o=1. Then ready=1 -> 4 results popped in order, one per cycle.
- Full FIFO with push and pop in the same cycle -> no drop, count stays 4, order preserved. Then assert srst_i mid-burst -> data_val_o=0 and all outputs 0 asynchronously.
